// File: rtl/psum_acc_bias.sv
// Per-column psum accumulator seeded with bias; result held under valid/ready until consumed.
// Latency: N+1 cycles start-to-valid with back-to-back beats; define ACC_SAT_EN for saturating accumulate (default wraps).
module psum_acc_bias #(
    parameter int COLS    = 5,
    parameter int PS_BW   = 16,
    parameter int BI_BW   = 16,
    parameter int AB_BW   = 25,
    parameter int PASS_BW = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_start,
    input  logic [PASS_BW-1:0]       i_num_pass,
    input  logic [BI_BW*COLS-1:0]    i_bias,
    input  logic                     i_psum_valid,
    input  logic [PS_BW*COLS-1:0]    i_psum,
    output logic                     o_psum_ready,
    output logic                     o_acc_valid,
    input  logic                     i_acc_ready,
    output logic [AB_BW*COLS-1:0]    o_acc_bias,
    output logic                     o_busy,
    output logic                     o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PASS_BW-1:0]   r_cnt;
    logic                 r_done;

    logic w_start;
    logic w_beat;
    logic w_last;
    logic w_hs;

    // A zero pass count would never reach OUT, so such a start is dropped.
    assign w_start = (r_state == S_IDLE) & i_start & (i_num_pass != '0);
    assign w_beat  = (r_state == S_ACCUM) & i_psum_valid;
    assign w_last  = w_beat & (r_cnt == PASS_BW'(1));
    assign w_hs    = (r_state == S_OUT) & i_acc_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start)     w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_last)      w_state_nxt = S_OUT;
            S_OUT:   if (i_acc_ready) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_hs;
            if (w_start) begin
                r_cnt <= i_num_pass;
            end else if (w_beat) begin
                r_cnt <= r_cnt - PASS_BW'(1);
            end
        end
    end

    for (genvar g = 0; g < COLS; g++) begin : g_col
        logic signed [BI_BW-1:0] w_bias_raw;
        logic signed [PS_BW-1:0] w_psum_raw;
        logic signed [AB_BW-1:0] w_bias_ext;
        logic signed [AB_BW-1:0] w_psum_ext;
        logic signed [AB_BW-1:0] w_sum;
        logic signed [AB_BW-1:0] r_acc;

        assign w_bias_raw = i_bias[(g+1)*BI_BW-1 -: BI_BW];
        assign w_psum_raw = i_psum[(g+1)*PS_BW-1 -: PS_BW];
        assign w_bias_ext = AB_BW'(w_bias_raw);
        assign w_psum_ext = AB_BW'(w_psum_raw);

`ifdef ACC_SAT_EN
        // One guard bit: top two bits disagreeing means the add left the AB_BW range.
        logic [AB_BW:0] w_sum_full;
        assign w_sum_full = {r_acc[AB_BW-1], r_acc} + {w_psum_ext[AB_BW-1], w_psum_ext};
        always_comb begin
            w_sum = w_sum_full[AB_BW-1:0];
            if (w_sum_full[AB_BW] != w_sum_full[AB_BW-1]) begin
                w_sum = w_sum_full[AB_BW] ? {1'b1, {(AB_BW-1){1'b0}}}
                                          : {1'b0, {(AB_BW-1){1'b1}}};
            end
        end
`else
        assign w_sum = r_acc + w_psum_ext;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_acc <= '0;
            end else if (w_start) begin
                r_acc <= w_bias_ext;
            end else if (w_beat) begin
                r_acc <= w_sum;
            end
        end

        assign o_acc_bias[(g+1)*AB_BW-1 -: AB_BW] = r_acc;
    end

    assign o_psum_ready = (r_state == S_ACCUM);
    assign o_acc_valid  = (r_state == S_OUT);
    assign o_busy       = (r_state != S_IDLE);
    assign o_done       = r_done;

endmodule

// File: tb/tb_psum_acc_bias.sv
// Directed bench for psum_acc_bias with hand-computed expected results.
module tb_psum_acc_bias;
    // Count field widened so the 1000-beat overflow job fits.
    localparam int COLS    = 5;
    localparam int PS_BW   = 16;
    localparam int BI_BW   = 16;
    localparam int AB_BW   = 25;
    localparam int PASS_BW = 10;

    logic                  clk;
    logic                  rst_n;
    logic                  i_start;
    logic [PASS_BW-1:0]    i_num_pass;
    logic [BI_BW*COLS-1:0] i_bias;
    logic                  i_psum_valid;
    logic [PS_BW*COLS-1:0] i_psum;
    logic                  o_psum_ready;
    logic                  o_acc_valid;
    logic                  i_acc_ready;
    logic [AB_BW*COLS-1:0] o_acc_bias;
    logic                  o_busy;
    logic                  o_done;

    int n_chk = 0;
    int n_err = 0;

    psum_acc_bias #(
        .COLS(COLS), .PS_BW(PS_BW), .BI_BW(BI_BW), .AB_BW(AB_BW), .PASS_BW(PASS_BW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_num_pass(i_num_pass),
        .i_bias(i_bias), .i_psum_valid(i_psum_valid), .i_psum(i_psum),
        .o_psum_ready(o_psum_ready), .o_acc_valid(o_acc_valid), .i_acc_ready(i_acc_ready),
        .o_acc_bias(o_acc_bias), .o_busy(o_busy), .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16*COLS-1:0] pk(input int v[COLS]);
        logic [16*COLS-1:0] r;
        r = '0;
        for (int i = 0; i < COLS; i++) r[i*16 +: 16] = v[i][15:0];
        return r;
    endfunction

    function automatic logic signed [63:0] col(input int i);
        logic signed [AB_BW-1:0] s;
        s = o_acc_bias[i*AB_BW +: AB_BW];
        return 64'(s);
    endfunction

    task automatic start_job(input int n, input int b[COLS]);
        i_start    = 1'b1;
        i_num_pass = PASS_BW'(n);
        i_bias     = pk(b);
        tick();
        i_start    = 1'b0;
    endtask

    task automatic beat(input int p[COLS]);
        i_psum_valid = 1'b1;
        i_psum       = pk(p);
        tick();
        i_psum_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        i_acc_ready = 1'b1;
        tick();
        i_acc_ready = 1'b0;
        chk({tag, "_done"}, 64'(o_done), 64'(1));
        chk({tag, "_vld_lo"}, 64'(o_acc_valid), 64'(0));
        chk({tag, "_busy_lo"}, 64'(o_busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b[COLS];
        int p[COLS];
        logic signed [63:0] hold;

        rst_n = 1'b1; i_start = 1'b0; i_num_pass = '0; i_bias = '0;
        i_psum_valid = 1'b0; i_psum = '0; i_acc_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(o_busy), 64'(0));
        chk("rst_rdy", 64'(o_psum_ready), 64'(0));
        chk("rst_vld", 64'(o_acc_valid), 64'(0));
        chk("rst_done", 64'(o_done), 64'(0));
        chk("rst_acc0", col(0), 0);
        #18 rst_n = 1'b1;
        tick();

        // Basic three-beat job, back-to-back beats.
        b = '{10, -5, 0, 32767, -32768};
        start_job(3, b);
        chk("b_busy", 64'(o_busy), 64'(1));
        chk("b_rdy", 64'(o_psum_ready), 64'(1));
        p = '{100, 1, 2, 3, 4};     beat(p);
        p = '{-20, -1, -2, -3, -4}; beat(p);
        chk("b_vld_early", 64'(o_acc_valid), 64'(0));
        p = '{5, 7, 8, 9, -10};     beat(p);
        chk("b_vld", 64'(o_acc_valid), 64'(1));
        chk("b_rdy_lo", 64'(o_psum_ready), 64'(0));
        chk("b_col0", col(0), 95);
        chk("b_col1", col(1), 2);
        chk("b_col2", col(2), 8);
        chk("b_col3", col(3), 32776);
        chk("b_col4", col(4), -32778);
        handshake("b");
        tick();
        chk("b_done_once", 64'(o_done), 64'(0));

        // Bubbles between beats, then held backpressure with stray valid beats.
        b = '{1, 1, 1, 1, 1};
        start_job(2, b);
        p = '{10, 10, 10, 10, 10}; beat(p);
        i_psum = pk('{999, 999, 999, 999, 999});
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bb_bubble_vld", 64'(o_acc_valid), 64'(0));
        end
        p = '{20, 20, 20, 20, -40}; beat(p);
        chk("bb_col0", col(0), 31);
        chk("bb_col4", col(4), -29);
        i_psum_valid = 1'b1;
        hold = col(0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bb_hold_vld", 64'(o_acc_valid), 64'(1));
            chk("bb_hold_col0", col(0), 31);
            chk("bb_hold_done", 64'(o_done), 64'(0));
        end
        i_psum_valid = 1'b0;
        chk("bb_hold_same", col(0), hold);
        handshake("bb");
        tick();
        chk("bb_done_once", 64'(o_done), 64'(0));

        // Ignored starts: zero count, and a restart while accumulating.
        b = '{7, 7, 7, 7, 7};
        start_job(0, b);
        chk("ig_busy0", 64'(o_busy), 64'(0));
        b = '{100, 100, 100, 100, 100};
        start_job(2, b);
        b = '{5000, 5000, 5000, 5000, 5000};
        start_job(7, b);
        p = '{1, 1, 1, 1, 1}; beat(p);
        p = '{1, 1, 1, 1, 2}; beat(p);
        chk("ig_vld", 64'(o_acc_valid), 64'(1));
        chk("ig_col0", col(0), 102);
        chk("ig_col4", col(4), 103);
        handshake("ig");

        // Async reset after 2 of 4 beats discards the partial sum.
        b = '{50, 50, 50, 50, 50};
        start_job(4, b);
        p = '{1000, 1000, 1000, 1000, 1000}; beat(p); beat(p);
        rst_n = 1'b0;
        #1;
        chk("rr_busy", 64'(o_busy), 64'(0));
        chk("rr_rdy", 64'(o_psum_ready), 64'(0));
        chk("rr_col0", col(0), 0);
        chk("rr_col3", col(3), 0);
        #3 rst_n = 1'b1;
        tick();
        start_job(1, b);
        p = '{3, 3, 3, 3, 3}; beat(p);
        chk("rr_fresh_vld", 64'(o_acc_valid), 64'(1));
        chk("rr_fresh_col0", col(0), 53);

        // Back-to-back jobs: start on the cycle right after the handshake.
        handshake("bt_a");
        b = '{-3, -3, -3, -3, -3};
        start_job(1, b);
        chk("bt_busy", 64'(o_busy), 64'(1));
        p = '{-4, -4, -4, -4, -4}; beat(p);
        chk("bt_col0", col(0), -7);
        chk("bt_col2", col(2), -7);
        handshake("bt_b");

        // Overflow: 1000 beats of +32767 in col0, -32768 in col1.
        b = '{0, 0, 0, 0, 0};
        start_job(1000, b);
        i_psum_valid = 1'b1;
        i_psum = pk('{32767, -32768, 1, 0, 0});
        for (int k = 0; k < 1000; k++) tick();
        i_psum_valid = 1'b0;
        chk("ov_vld", 64'(o_acc_valid), 64'(1));
`ifdef ACC_SAT_EN
        chk("ov_col0", col(0), 16777215);
        chk("ov_col1", col(1), -16777216);
`else
        chk("ov_col0", col(0), -787432);
        chk("ov_col1", col(1), 786432);
`endif
        chk("ov_col2", col(2), 1000);
        handshake("ov");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
